// File: rtl/cdc_sync_filter.sv
// Multi-channel synchroniser with per-channel stability filter and edge pulses.
// Each din bit crosses an N-flop chain, then must hold FILTER_CYCLES samples before dout follows.
module cdc_sync_filter #(
    parameter int                     N             = 2,
    parameter int                     WIDTH         = 1,
    parameter int                     FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0]       RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    generate
        if (N < 2) begin : g_bad_n
            $error("cdc_sync_filter: N must be >= 2");
        end
        if (FILTER_CYCLES < 1) begin : g_bad_filter
            $error("cdc_sync_filter: FILTER_CYCLES must be >= 1");
        end
    endgenerate

    (* ASYNC_REG = "TRUE", SILISCALE_CDC = "TRUE" *)
    logic [WIDTH-1:0] sync_q [N];

    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] s;

    assign s = sync_q[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < N; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // cnt counts consecutive synced samples that disagree with dout; any agreeing
    // sample restarts qualification, which is what rejects short glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == dout[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    dout[i] <= s[i];
                    rise[i] <= s[i];
                    fall[i] <= ~s[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule
